fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side companion of the stream_resize FIFO. Drains wide words through the FIFO's pop/empty
//  interface and serialises each word into RATIO narrow beats on a valid/ready master stream.
//  Least-significant slice goes first; m_last marks the final slice of each word.
//  Sits between the FIFO read port and the downstream narrow-stream consumer.
// PARAMETERS
//  IN_WIDTH   32                   FIFO word width; must be an integer multiple of OUT_WIDTH
//  OUT_WIDTH  8                    output beat width
//  RATIO      IN_WIDTH/OUT_WIDTH   beats per word (derived; must be >= 1)
//  CNT_WIDTH  $clog2(RATIO)+1      width of the beat counter (derived)
// PORTS
//  clk         in   1          clock, all logic on posedge
//  rst         in   1          synchronous reset, active-high
//  fifo_data   in   IN_WIDTH   FIFO out_data; valid the cycle after fifo_pop=1
//  fifo_empty  in   1          FIFO empty flag
//  fifo_pop    out  1          pop request to FIFO (combinational)
//  m_data      out  OUT_WIDTH  current beat
//  m_valid     out  1          beat valid
//  m_ready     in   1          consumer ready
//  m_last      out  1          current beat is slice RATIO-1 of its word
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-high on rst.
//  - Reset: m_valid=0, m_last=0, m_data=0, beat counter=0, pf_valid=0, inflight=0.
//    fifo_pop=0 while rst=1.
//  - Storage: shifter (IN_WIDTH, beat counter, sh_valid), prefetch register pf (IN_WIDTH, pf_valid),
//    inflight flag.
//  - FIFO read timing: fifo_data is registered in the FIFO. A pop in cycle t presents the word in
//    cycle t+1 only. fifo_data is not sampled in any other cycle.
//  - fifo_pop = !rst & !fifo_empty & !inflight & !pf_valid. inflight <= fifo_pop.
//  - Word landing in cycle t+1 (inflight=1): loads the shifter directly (bypass) if the shifter is
//    empty or its last beat is accepted that cycle; otherwise it loads pf.
//  - Shifter load priority: pf first when pf_valid=1, else the bypass word. A pf transfer clears
//    pf_valid in the same edge.
//  - Handshake: a beat transfers when m_valid & m_ready. m_data is the counter-selected slice,
//    bits [cnt*OUT_WIDTH +: OUT_WIDTH].
//  - While m_valid=1 & m_ready=0: m_data, m_last and m_valid are held stable, no counter change.
//  - Counter advances on a transfer. It wraps to 0 on the last beat, and that same edge reloads or
//    empties the shifter.
//  - m_last = m_valid & (cnt == RATIO-1). For RATIO=1, every beat has m_last=1.
//  - Latency: pop in cycle 0 -> first beat m_valid=1 in cycle 2.
//  - Throughput with RATIO>=2 and FIFO non-empty: one beat per cycle, no bubbles across words.
//    With RATIO=1: one beat per 2 cycles.
//  - Never pops when fifo_empty=1. At most one pop outstanding. Never drops or duplicates a word.
//  - Reset mid-word: partial word, pf and any in-flight word are discarded. The next word after
//    reset starts at slice 0.
//    rst must be asserted together with the FIFO reset.
// STRUCTURE
//  - stream_resize_pkg: slice_count(in_w, out_w) function; elaboration check that IN_WIDTH %
//    OUT_WIDTH == 0.
//  - Single module. Shifter plus counter is the natural sub-module: stream_word_serializer
//    (load/valid/ready/last).
// TESTING  (IN_WIDTH=32, OUT_WIDTH=8 unless stated)
//  1. rst=1 for 2 cycles, fifo_empty=0 -> fifo_pop=0, m_valid=0, m_last=0, m_data=0 throughout.
//  2. Word 0xDDCCBBAA, m_ready=1, pop in cycle 0:
//     - beats AA,BB,CC,DD in cycles 2..5; m_last=1 only on DD;
//     - m_valid=0 in cycle 6.
//  3. Two words 0x44332211, 0x88776655, m_ready=1:
//     - pops in cycles 0 and 2;
//     - beats 11..88 in cycles 2..9 with no bubble; m_last=1 in cycles 5 and 9.
//  4. Backpressure: m_ready=0 for cycles 3..5 of test 2:
//     - m_data=BB held, m_valid=1;
//     - no fifo_pop while pf_valid=1; CC appears in cycle 7.
//  5. rst pulse in cycle 3 of test 2 (after AA accepted):
//     - m_valid=0 in cycle 4;
//     - a new word 0x0000CAFE then emits FE,CA,00,00 from slice 0.
//  6. IN=OUT=8, FIFO holding 0x01,0x02,0x03, m_ready=1:
//     - beats 01,02,03, each with m_last=1, one per 2 cycles;
//     - fifo_pop never asserted while fifo_empty=1.

Source files
------------

// File: rtl/stream_resize_pkg.sv
// Shared helpers for the stream_resize FIFO read path.
package stream_resize_pkg;

   // Number of narrow slices carried by one wide word.
   function automatic int slice_count(input int in_w, input int out_w);
      return (out_w > 0) ? (in_w / out_w) : 0;
   endfunction

   // Where the shifter takes its next word from.
   typedef enum logic [1:0] {
      LD_NONE   = 2'd0,
      LD_PF     = 2'd1,
      LD_BYPASS = 2'd2
   } load_src_e;

endpackage

// File: rtl/stream_word_serializer.sv
// Holds one wide word and emits it LSB slice first on a valid/ready stream.
module stream_word_serializer
   import stream_resize_pkg::*;
#(
   parameter int OUT_WIDTH = 8,
   parameter int RATIO     = 4,
   parameter int CNT_WIDTH = $clog2(RATIO) + 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            load,
   input  logic [RATIO-1:0][OUT_WIDTH-1:0] load_data,
   output logic                            load_ready,
   output logic [OUT_WIDTH-1:0]            m_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic                            m_last
);

   logic [RATIO-1:0][OUT_WIDTH-1:0] sh_q;
   logic [CNT_WIDTH-1:0]            cnt;
   logic                            sh_valid;
   logic                            last_beat;
   logic                            xfer;
   logic [OUT_WIDTH-1:0]            slice;

   assign last_beat  = (cnt == CNT_WIDTH'(RATIO - 1));
   assign xfer       = sh_valid & m_ready;
   // Free either when idle or when the final slice leaves this cycle.
   assign load_ready = !sh_valid | (xfer & last_beat);

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q     <= '0;
         cnt      <= '0;
         sh_valid <= 1'b0;
      end else if (load) begin
         sh_q     <= load_data;
         cnt      <= '0;
         sh_valid <= 1'b1;
      end else if (xfer) begin
         if (last_beat) begin
            cnt      <= '0;
            sh_valid <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      slice = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (cnt == CNT_WIDTH'(i)) slice = sh_q[i];
      end
   end

   assign m_valid = sh_valid;
   assign m_data  = sh_valid ? slice : '0;
   assign m_last  = sh_valid & last_beat;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains wide words from a registered-output FIFO and serialises them into narrow beats.
module fifo_stream_reader
   import stream_resize_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_pop,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last
);

   localparam int RATIO     = slice_count(IN_WIDTH, OUT_WIDTH);
   localparam int CNT_WIDTH = $clog2(RATIO) + 1;

   if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 1)) begin : g_width_check
      $error("fifo_stream_reader: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
   end

   logic                inflight;
   logic                pf_valid;
   logic [IN_WIDTH-1:0] pf_q;
   logic                sh_ready;
   logic                sh_load;
   logic [IN_WIDTH-1:0] sh_load_data;
   logic                pf_fill;
   load_src_e           load_src;

   // One pop outstanding at most, and none while a word is parked in pf.
   assign fifo_pop = !rst & !fifo_empty & !inflight & !pf_valid;

   always_comb begin
      load_src = LD_NONE;
      if (sh_ready) begin
         if (pf_valid)      load_src = LD_PF;
         else if (inflight) load_src = LD_BYPASS;
      end
   end

   assign sh_load      = (load_src != LD_NONE);
   assign sh_load_data = (load_src == LD_PF) ? pf_q : fifo_data;
   // fifo_data is only meaningful while inflight; park it if the shifter can't take it.
   assign pf_fill      = inflight & (load_src != LD_BYPASS);

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
         pf_valid <= 1'b0;
         pf_q     <= '0;
      end else begin
         inflight <= fifo_pop;
         if (pf_fill) begin
            pf_q     <= fifo_data;
            pf_valid <= 1'b1;
         end else if (load_src == LD_PF) begin
            pf_valid <= 1'b0;
         end
      end
   end

   stream_word_serializer #(
      .OUT_WIDTH (OUT_WIDTH),
      .RATIO     (RATIO),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load       (sh_load),
      .load_data  (sh_load_data),
      .load_ready (sh_ready),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: 32->8 reader plus an 8->8 reader, each fed by a registered-output FIFO model.
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [31:0] fifo_data = '0;
   logic        fifo_empty;
   logic        fifo_pop;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        m_last;

   logic [7:0]  fifo_data8 = '0;
   logic        fifo_empty8;
   logic        fifo_pop8;
   logic [7:0]  m_data8;
   logic        m_valid8;
   logic        m_ready8 = 1'b1;
   logic        m_last8;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fifo_stream_reader #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_pop(fifo_pop), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last)
   );

   fifo_stream_reader #(.IN_WIDTH(8), .OUT_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .fifo_data(fifo_data8), .fifo_empty(fifo_empty8),
      .fifo_pop(fifo_pop8), .m_data(m_data8), .m_valid(m_valid8), .m_ready(m_ready8),
      .m_last(m_last8)
   );

   // FIFO models: word appears on fifo_data the cycle after a pop; reset flushes.
   logic [31:0] mem [0:63];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic [7:0]  mem8 [0:7];
   int          wr8 = 0;
   int          rd8 = 0;

   assign fifo_empty  = (rd_ptr == wr_ptr);
   assign fifo_empty8 = (rd8 == wr8);

   always @(posedge clk) begin
      if (rst) begin
         rd_ptr <= wr_ptr;
         rd8    <= wr8;
      end else begin
         if (fifo_pop && rd_ptr != wr_ptr) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
         end
         if (fifo_pop8 && rd8 != wr8) begin
            fifo_data8 <= mem8[rd8];
            rd8        <= rd8 + 1;
         end
      end
   end

   task automatic push(input logic [31:0] w);
      mem[wr_ptr] = w;
      wr_ptr++;
   endtask

   task automatic push8(input logic [7:0] w);
      mem8[wr8] = w;
      wr8++;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      push(32'h12345678);
      #1;
      checks++;
      if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop_async got %b want 0", fifo_pop); end
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop c%0d got %b want 0", c, fifo_pop); end
         checks++;
         if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid c%0d got %b want 0", c, m_valid); end
         checks++;
         if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last c%0d got %b want 0", c, m_last); end
         checks++;
         if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data c%0d got %h want 00", c, m_data); end
      end
      rst = 1'b0;
   endtask

   task automatic test_single_word();
      bit         ep [7] = '{1, 0, 0, 0, 0, 0, 0};
      bit         ev [7] = '{0, 0, 1, 1, 1, 1, 0};
      bit         el [7] = '{0, 0, 0, 0, 0, 1, 0};
      logic [7:0] ed [7] = '{8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      do_reset();
      push(32'hDDCCBBAA);
      #1;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) step();
         checks++;
         if (fifo_pop !== ep[c]) begin errors++; $display("FAIL single_pop c%0d got %b want %b", c, fifo_pop, ep[c]); end
         checks++;
         if (m_valid !== ev[c]) begin errors++; $display("FAIL single_valid c%0d got %b want %b", c, m_valid, ev[c]); end
         checks++;
         if (m_last !== el[c]) begin errors++; $display("FAIL single_last c%0d got %b want %b", c, m_last, el[c]); end
         if (ev[c]) begin
            checks++;
            if (m_data !== ed[c]) begin errors++; $display("FAIL single_data c%0d got %h want %h", c, m_data, ed[c]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit         ep [11] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      bit         ev [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      bit         el [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
      logic [7:0] ed [11] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      do_reset();
      push(32'h44332211);
      push(32'h88776655);
      #1;
      for (int c = 0; c < 11; c++) begin
         if (c > 0) step();
         checks++;
         if (fifo_pop !== ep[c]) begin errors++; $display("FAIL b2b_pop c%0d got %b want %b", c, fifo_pop, ep[c]); end
         checks++;
         if (m_valid !== ev[c]) begin errors++; $display("FAIL b2b_valid c%0d got %b want %b", c, m_valid, ev[c]); end
         checks++;
         if (m_last !== el[c]) begin errors++; $display("FAIL b2b_last c%0d got %b want %b", c, m_last, el[c]); end
         if (ev[c]) begin
            checks++;
            if (m_data !== ed[c]) begin errors++; $display("FAIL b2b_data c%0d got %h want %h", c, m_data, ed[c]); end
         end
      end
   endtask

   // Three words; consumer stalls in cycles 3..5, so the second word parks in pf
   // and the third may only be popped once pf drains.
   task automatic test_backpressure();
      bit         rd [18] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      bit         ep [18] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      bit         ev [18] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      bit         el [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
      logic [7:0] ed [18] = '{8'h00, 8'h00, 8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hDD,
                              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      do_reset();
      push(32'hDDCCBBAA);
      push(32'h44332211);
      push(32'h88776655);
      #1;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) step();
         m_ready = rd[c];
         checks++;
         if (fifo_pop !== ep[c]) begin errors++; $display("FAIL bp_pop c%0d got %b want %b", c, fifo_pop, ep[c]); end
         checks++;
         if (m_valid !== ev[c]) begin errors++; $display("FAIL bp_valid c%0d got %b want %b", c, m_valid, ev[c]); end
         checks++;
         if (m_last !== el[c]) begin errors++; $display("FAIL bp_last c%0d got %b want %b", c, m_last, el[c]); end
         if (ev[c]) begin
            checks++;
            if (m_data !== ed[c]) begin errors++; $display("FAIL bp_data c%0d got %h want %h", c, m_data, ed[c]); end
         end
      end
      m_ready = 1'b1;
   endtask

   // rst in cycle 3 (after AA) drops the partial word and the second word already popped.
   task automatic test_reset_mid_word();
      logic [7:0] ed [4] = '{8'hFE, 8'hCA, 8'h00, 8'h00};
      do_reset();
      push(32'hDDCCBBAA);
      push(32'h12345678);
      #1;
      for (int c = 1; c < 4; c++) step();
      checks++;
      if (m_data !== 8'hBB) begin errors++; $display("FAIL mid_pre_data got %h want bb", m_data); end
      rst = 1'b1;
      #1;
      checks++;
      if (fifo_pop !== 1'b0) begin errors++; $display("FAIL mid_rst_pop got %b want 0", fifo_pop); end
      step();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_c4 got %b want 0", m_valid); end
      rst = 1'b0;
      push(32'h0000CAFE);
      #1;
      checks++;
      if (fifo_pop !== 1'b1) begin errors++; $display("FAIL mid_new_pop got %b want 1", fifo_pop); end
      step();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_c5 got %b want 0", m_valid); end
      for (int b = 0; b < 4; b++) begin
         step();
         checks++;
         if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_beat_valid b%0d got %b want 1", b, m_valid); end
         checks++;
         if (m_data !== ed[b]) begin errors++; $display("FAIL mid_beat_data b%0d got %h want %h", b, m_data, ed[b]); end
         checks++;
         if (m_last !== (b == 3)) begin errors++; $display("FAIL mid_beat_last b%0d got %b want %b", b, m_last, (b == 3)); end
      end
      step();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_tail_valid got %b want 0", m_valid); end
   endtask

   task automatic test_ratio_one();
      bit         ep [8] = '{1, 0, 1, 0, 1, 0, 0, 0};
      bit         ev [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
      logic [7:0] ed [8] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
      do_reset();
      push8(8'h01);
      push8(8'h02);
      push8(8'h03);
      #1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) step();
         checks++;
         if (fifo_pop8 !== ep[c]) begin errors++; $display("FAIL r1_pop c%0d got %b want %b", c, fifo_pop8, ep[c]); end
         checks++;
         if ((fifo_pop8 & fifo_empty8) !== 1'b0) begin errors++; $display("FAIL r1_pop_empty c%0d got 1 want 0", c); end
         checks++;
         if (m_valid8 !== ev[c]) begin errors++; $display("FAIL r1_valid c%0d got %b want %b", c, m_valid8, ev[c]); end
         checks++;
         if (m_last8 !== ev[c]) begin errors++; $display("FAIL r1_last c%0d got %b want %b", c, m_last8, ev[c]); end
         if (ev[c]) begin
            checks++;
            if (m_data8 !== ed[c]) begin errors++; $display("FAIL r1_data c%0d got %h want %h", c, m_data8, ed[c]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      test_ratio_one();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
